// File: rtl/fu_ctrl_port.sv
// fu_ctrl_port
// Controller-side endpoint of one functional unit. Issued instructions are
// buffered in a small issue queue and presented to the FU from its head;
// FU issue is metered by result credits so that the result FIFO can never
// overflow (FU results carry no backpressure). Captured results drain to
// writeback through a valid/ready handshake. A flush empties both queues and
// arranges for the results still in flight to be discarded on arrival.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   iss_*                    issue side: valid/ready + instruction fields
//   inst_id/inst/op/out_prn/pc, inst_valid, fu_ready   drive to the FU
//   fu_out_*                 FU result strobe and fields (no backpressure)
//   wb_*                     writeback side: valid/ready + result fields
//   flush                    synchronous squash
//   proto_err                sticky: result strobe seen with nothing in flight
module fu_ctrl_port #(
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int ISSUE_DEPTH  = 2,
  parameter int RESULT_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    iss_valid,
  output logic                    iss_ready,
  input  logic [INST_ID_BITS-1:0] iss_inst_id,
  input  logic [31:0]             iss_inst,
  input  logic [63:0]             iss_op [MAX_OPERANDS],
  input  logic [PRN_BITS-1:0]     iss_out_prn [MAX_OPERANDS],
  input  logic [63:0]             iss_pc,
  output logic [INST_ID_BITS-1:0] inst_id,
  output logic [31:0]             inst,
  output logic [63:0]             op [MAX_OPERANDS],
  output logic [PRN_BITS-1:0]     out_prn [MAX_OPERANDS],
  output logic [63:0]             pc,
  output logic                    inst_valid,
  input  logic                    fu_ready,
  input  logic [PRN_BITS-1:0]     fu_out_prn [MAX_OPERANDS],
  input  logic [63:0]             fu_out_data [MAX_OPERANDS],
  input  logic                    fu_out_data_valid [MAX_OPERANDS],
  input  logic [INST_ID_BITS-1:0] fu_out_inst_id,
  input  logic                    fu_out_valid,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [INST_ID_BITS-1:0] wb_inst_id,
  output logic [PRN_BITS-1:0]     wb_prn [MAX_OPERANDS],
  output logic [63:0]             wb_data [MAX_OPERANDS],
  output logic                    wb_data_valid [MAX_OPERANDS],
  input  logic                    flush,
  output logic                    proto_err
);

  localparam int ICW = $clog2(ISSUE_DEPTH + 1);
  localparam int IPW = $clog2(ISSUE_DEPTH);
  localparam int RCW = $clog2(RESULT_DEPTH + 1);
  localparam int RPW = $clog2(RESULT_DEPTH);

  logic [INST_ID_BITS-1:0] iq_id   [ISSUE_DEPTH];
  logic [31:0]             iq_inst [ISSUE_DEPTH];
  logic [63:0]             iq_op   [ISSUE_DEPTH][MAX_OPERANDS];
  logic [PRN_BITS-1:0]     iq_prn  [ISSUE_DEPTH][MAX_OPERANDS];
  logic [63:0]             iq_pc   [ISSUE_DEPTH];
  logic [IPW-1:0]          iq_wr, iq_rd;
  logic [ICW-1:0]          iss_count;

  logic [INST_ID_BITS-1:0] rq_id   [RESULT_DEPTH];
  logic [PRN_BITS-1:0]     rq_prn  [RESULT_DEPTH][MAX_OPERANDS];
  logic [63:0]             rq_data [RESULT_DEPTH][MAX_OPERANDS];
  logic                    rq_dv   [RESULT_DEPTH][MAX_OPERANDS];
  logic [RPW-1:0]          rq_wr, rq_rd;
  logic [RCW-1:0]          res_count;

  logic [RCW-1:0] credits, inflight, drop_cnt, inflight_left;
  logic push, accept, res_seen, drop, capture, wb_pop;

  assign iss_ready  = (iss_count < ICW'(ISSUE_DEPTH)) && !flush;
  assign inst_valid = (iss_count != '0) && (credits != '0) && !flush;
  assign wb_valid   = (res_count != '0);

  assign push     = iss_valid && iss_ready;
  assign accept   = inst_valid && fu_ready;
  // A strobe with nothing in flight is a protocol error and is otherwise ignored.
  assign res_seen = fu_out_valid && (inflight != '0);
  assign drop     = res_seen && (drop_cnt != '0);
  assign capture  = res_seen && (drop_cnt == '0) && !flush;
  assign wb_pop   = wb_valid && wb_ready && !flush;
  // In-flight count after retiring a result that arrives in the flush cycle.
  assign inflight_left = inflight - RCW'(res_seen);

  assign inst_id    = iq_id[iq_rd];
  assign inst       = iq_inst[iq_rd];
  assign pc         = iq_pc[iq_rd];
  assign wb_inst_id = rq_id[rq_rd];

  always_comb begin
    for (int unsigned i = 0; i < MAX_OPERANDS; i++) begin
      op[i]            = iq_op[iq_rd][i];
      out_prn[i]       = iq_prn[iq_rd][i];
      wb_prn[i]        = rq_prn[rq_rd][i];
      wb_data[i]       = rq_data[rq_rd][i];
      wb_data_valid[i] = rq_dv[rq_rd][i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iq_wr     <= '0;
      iq_rd     <= '0;
      iss_count <= '0;
      for (int unsigned e = 0; e < ISSUE_DEPTH; e++) begin
        iq_id[e]   <= '0;
        iq_inst[e] <= '0;
        iq_pc[e]   <= '0;
        for (int unsigned i = 0; i < MAX_OPERANDS; i++) begin
          iq_op[e][i]  <= '0;
          iq_prn[e][i] <= '0;
        end
      end
    end else if (flush) begin
      iq_wr     <= '0;
      iq_rd     <= '0;
      iss_count <= '0;
    end else begin
      if (push) begin
        iq_id[iq_wr]   <= iss_inst_id;
        iq_inst[iq_wr] <= iss_inst;
        iq_pc[iq_wr]   <= iss_pc;
        for (int unsigned i = 0; i < MAX_OPERANDS; i++) begin
          iq_op[iq_wr][i]  <= iss_op[i];
          iq_prn[iq_wr][i] <= iss_out_prn[i];
        end
        iq_wr <= iq_wr + IPW'(1);
      end
      if (accept) iq_rd <= iq_rd + IPW'(1);
      if (push && !accept)      iss_count <= iss_count + ICW'(1);
      else if (!push && accept) iss_count <= iss_count - ICW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rq_wr     <= '0;
      rq_rd     <= '0;
      res_count <= '0;
      for (int unsigned e = 0; e < RESULT_DEPTH; e++) begin
        rq_id[e] <= '0;
        for (int unsigned i = 0; i < MAX_OPERANDS; i++) begin
          rq_prn[e][i]  <= '0;
          rq_data[e][i] <= '0;
          rq_dv[e][i]   <= 1'b0;
        end
      end
    end else if (flush) begin
      rq_wr     <= '0;
      rq_rd     <= '0;
      res_count <= '0;
    end else begin
      if (capture) begin
        rq_id[rq_wr] <= fu_out_inst_id;
        for (int unsigned i = 0; i < MAX_OPERANDS; i++) begin
          rq_prn[rq_wr][i]  <= fu_out_prn[i];
          rq_data[rq_wr][i] <= fu_out_data[i];
          rq_dv[rq_wr][i]   <= fu_out_data_valid[i];
        end
        rq_wr <= rq_wr + RPW'(1);
      end
      if (wb_pop) rq_rd <= rq_rd + RPW'(1);
      if (capture && !wb_pop)      res_count <= res_count + RCW'(1);
      else if (!capture && wb_pop) res_count <= res_count - RCW'(1);
    end
  end

  // credits + inflight + res_count stays equal to RESULT_DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits  <= RCW'(RESULT_DEPTH);
      inflight <= '0;
      drop_cnt <= '0;
    end else if (flush) begin
      inflight <= inflight_left;
      drop_cnt <= inflight_left;
      credits  <= RCW'(RESULT_DEPTH) - inflight_left;
    end else begin
      credits  <= credits - RCW'(accept) + RCW'(wb_pop) + RCW'(drop);
      inflight <= inflight + RCW'(accept) - RCW'(res_seen);
      if (drop) drop_cnt <= drop_cnt - RCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             proto_err <= 1'b0;
    else if (fu_out_valid && inflight == '0) proto_err <= 1'b1;
  end

endmodule

// File: tb/tb_fu_ctrl_port.sv
module tb_fu_ctrl_port;
  localparam int IB = 6;
  localparam int PB = 6;
  localparam int NO = 3;
  localparam int ID = 2;
  localparam int RD = 4;

  logic clk = 1'b0;
  logic rst;
  logic iss_valid, iss_ready;
  logic [IB-1:0] iss_inst_id;
  logic [31:0] iss_inst;
  logic [63:0] iss_op [NO];
  logic [PB-1:0] iss_out_prn [NO];
  logic [63:0] iss_pc;
  logic [IB-1:0] inst_id;
  logic [31:0] inst;
  logic [63:0] op [NO];
  logic [PB-1:0] out_prn [NO];
  logic [63:0] pc;
  logic inst_valid, fu_ready;
  logic [PB-1:0] fu_out_prn [NO];
  logic [63:0] fu_out_data [NO];
  logic fu_out_data_valid [NO];
  logic [IB-1:0] fu_out_inst_id;
  logic fu_out_valid;
  logic wb_valid, wb_ready;
  logic [IB-1:0] wb_inst_id;
  logic [PB-1:0] wb_prn [NO];
  logic [63:0] wb_data [NO];
  logic wb_data_valid [NO];
  logic flush, proto_err;

  always #5 clk = ~clk;

  fu_ctrl_port #(
    .INST_ID_BITS(IB), .PRN_BITS(PB), .MAX_OPERANDS(NO),
    .ISSUE_DEPTH(ID), .RESULT_DEPTH(RD)
  ) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_inst_id(iss_inst_id),
    .iss_inst(iss_inst), .iss_op(iss_op), .iss_out_prn(iss_out_prn), .iss_pc(iss_pc),
    .inst_id(inst_id), .inst(inst), .op(op), .out_prn(out_prn), .pc(pc),
    .inst_valid(inst_valid), .fu_ready(fu_ready),
    .fu_out_prn(fu_out_prn), .fu_out_data(fu_out_data), .fu_out_data_valid(fu_out_data_valid),
    .fu_out_inst_id(fu_out_inst_id), .fu_out_valid(fu_out_valid),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_inst_id(wb_inst_id),
    .wb_prn(wb_prn), .wb_data(wb_data), .wb_data_valid(wb_data_valid),
    .flush(flush), .proto_err(proto_err)
  );

  typedef struct packed {
    logic [IB-1:0]         id;
    logic [31:0]           inst;
    logic [NO-1:0][63:0]   op;
    logic [NO-1:0][PB-1:0] prn;
    logic [63:0]           pc;
  } iss_t;

  typedef struct packed {
    logic [IB-1:0]         id;
    logic [NO-1:0][PB-1:0] prn;
    logic [NO-1:0][63:0]   data;
    logic [NO-1:0]         dv;
  } res_t;

  // Reference model: queues and plain counters
  iss_t iss_q[$];
  res_t res_q[$];
  logic [IB-1:0] fu_pend[$];
  int m_credits, m_inflight, m_drop;
  bit m_perr;

  logic [IB-1:0] cur_id;
  logic [IB-1:0] acc_ids[$];
  logic [IB-1:0] wb_ids[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    iss_q.delete();
    res_q.delete();
    fu_pend.delete();
    m_credits = RD;
    m_inflight = 0;
    m_drop = 0;
    m_perr = 1'b0;
  endfunction

  task automatic drive(input bit iv, input bit fr, input bit wr, input bit fl, input bit fov);
    iss_valid = iv;
    iss_inst_id = cur_id;
    iss_inst = $urandom;
    iss_pc = {$urandom, $urandom};
    for (int i = 0; i < NO; i++) begin
      iss_op[i] = {$urandom, $urandom};
      iss_out_prn[i] = PB'($urandom);
      fu_out_prn[i] = PB'($urandom);
      fu_out_data[i] = {$urandom, $urandom};
      fu_out_data_valid[i] = 1'($urandom);
    end
    fu_ready = fr;
    wb_ready = wr;
    flush = fl;
    fu_out_valid = fov;
    fu_out_inst_id = IB'($urandom);
    if (fov && fu_pend.size() > 0) fu_out_inst_id = fu_pend.pop_front();
  endtask

  task automatic check_outputs();
    bit e_ir, e_iv, e_wv;
    iss_t h;
    res_t r;
    e_ir = (iss_q.size() < ID) && !flush;
    e_iv = (iss_q.size() != 0) && (m_credits != 0) && !flush;
    e_wv = (res_q.size() != 0);
    check_eq("iss_ready", iss_ready, e_ir);
    check_eq("inst_valid", inst_valid, e_iv);
    check_eq("wb_valid", wb_valid, e_wv);
    check_eq("proto_err", proto_err, m_perr);
    if (e_iv) begin
      h = iss_q[0];
      check_eq("inst_id", inst_id, h.id);
      check_eq("inst", inst, h.inst);
      check_eq("pc", pc, h.pc);
      for (int i = 0; i < NO; i++) begin
        check_eq($sformatf("op%0d", i), op[i], h.op[i]);
        check_eq($sformatf("out_prn%0d", i), out_prn[i], h.prn[i]);
      end
    end
    if (e_wv) begin
      r = res_q[0];
      check_eq("wb_inst_id", wb_inst_id, r.id);
      for (int i = 0; i < NO; i++) begin
        check_eq($sformatf("wb_prn%0d", i), wb_prn[i], r.prn[i]);
        check_eq($sformatf("wb_data%0d", i), wb_data[i], r.data[i]);
        check_eq($sformatf("wb_dv%0d", i), wb_data_valid[i], r.dv[i]);
      end
    end
    if (inst_valid && fu_ready) acc_ids.push_back(inst_id);
    if (wb_valid && wb_ready && !flush) wb_ids.push_back(wb_inst_id);
  endtask

  task automatic model_update();
    bit e_ir, e_iv, e_wv, push, acc, pop, res;
    iss_t c;
    res_t r;
    e_ir = (iss_q.size() < ID) && !flush;
    e_iv = (iss_q.size() != 0) && (m_credits != 0) && !flush;
    e_wv = (res_q.size() != 0);
    push = iss_valid && e_ir;
    acc  = e_iv && fu_ready;
    pop  = e_wv && wb_ready && !flush;
    res  = fu_out_valid && (m_inflight > 0);
    if (fu_out_valid && m_inflight == 0) m_perr = 1'b1;
    if (flush) begin
      iss_q.delete();
      res_q.delete();
      if (res) m_inflight--;
      m_drop = m_inflight;
      m_credits = RD - m_inflight;
    end else begin
      if (acc) begin
        fu_pend.push_back(iss_q[0].id);
        void'(iss_q.pop_front());
        m_credits--;
        m_inflight++;
      end
      if (res) begin
        m_inflight--;
        if (m_drop > 0) begin
          m_drop--;
          m_credits++;
        end else begin
          r.id = fu_out_inst_id;
          for (int i = 0; i < NO; i++) begin
            r.prn[i] = fu_out_prn[i];
            r.data[i] = fu_out_data[i];
            r.dv[i] = fu_out_data_valid[i];
          end
          res_q.push_back(r);
        end
      end
      if (pop) begin
        void'(res_q.pop_front());
        m_credits++;
      end
      if (push) begin
        c.id = iss_inst_id;
        c.inst = iss_inst;
        c.pc = iss_pc;
        for (int i = 0; i < NO; i++) begin
          c.op[i] = iss_op[i];
          c.prn[i] = iss_out_prn[i];
        end
        iss_q.push_back(c);
        cur_id = cur_id + 1'b1;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (k < 60 && !(iss_q.size() == 0 && fu_pend.size() == 0 && res_q.size() == 0)) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, fu_pend.size() > 0);
      cycle();
      k++;
    end
    check_eq("drain_bound", (iss_q.size() + fu_pend.size() + res_q.size()) == 0, 1'b1);
  endtask

  task automatic async_reset_pulse();
    #2;
    rst = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    cur_id = '0;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    check_eq("rst_iss_ready", iss_ready, 1'b1);
    check_eq("rst_inst_valid", inst_valid, 1'b0);
    check_eq("rst_wb_valid", wb_valid, 1'b0);
    check_eq("rst_proto_err", proto_err, 1'b0);
    check_eq("rst_inst_id", inst_id, 0);
    check_eq("rst_pc", pc, 0);
    check_eq("rst_op0", op[0], 0);
    check_eq("rst_wb_data0", wb_data[0], 0);
    release_reset();

    // Three back-to-back issues, FU always ready
    acc_ids.delete();
    cur_id = 6'd1;
    repeat (3) begin drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); cycle(); end
    repeat (3) begin drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); cycle(); end
    check_eq("order_count", acc_ids.size(), 3);
    for (int i = 0; i < 3 && i < acc_ids.size(); i++)
      check_eq($sformatf("order_id%0d", i), acc_ids[i], i + 1);
    drain();

    // Credit exhaustion with writeback stalled
    acc_ids.delete();
    cur_id = 6'd10;
    repeat (12) begin drive(cur_id < 15, 1'b1, 1'b0, 1'b0, fu_pend.size() > 0); cycle(); end
    check_eq("credit_stall_accepts", acc_ids.size(), 4);
    drive(1'b0, 1'b1, 1'b1, 1'b0, fu_pend.size() > 0); cycle();
    repeat (5) begin drive(1'b0, 1'b1, 1'b0, 1'b0, fu_pend.size() > 0); cycle(); end
    check_eq("credit_return_accepts", acc_ids.size(), 5);
    drain();

    // Result fields pass through unchanged and hold until wb_ready
    cur_id = 6'd20;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    fu_out_data[0] = 64'hDEAD_BEEF;
    fu_out_data_valid[0] = 1'b1;
    fu_out_data_valid[1] = 1'b0;
    fu_out_data_valid[2] = 1'b0;
    cycle();
    repeat (3) begin
      check_eq("db_wb_valid", wb_valid, 1'b1);
      check_eq("db_wb_id", wb_inst_id, 20);
      check_eq("db_wb_data0", wb_data[0], 64'hDEAD_BEEF);
      check_eq("db_wb_dv0", wb_data_valid[0], 1'b1);
      check_eq("db_wb_dv1", wb_data_valid[1], 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); cycle();
    check_eq("db_wb_popped", wb_valid, 1'b0);

    // Flush with two in flight: later results dropped, credits restored
    cur_id = 6'd30;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0); cycle();
    repeat (2) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1); cycle();
      check_eq("flush_drop_wb_valid", wb_valid, 1'b0);
    end
    acc_ids.delete();
    cur_id = 6'd50;
    repeat (10) begin drive(cur_id < 54, 1'b1, 1'b0, 1'b0, 1'b0); cycle(); end
    check_eq("flush_credits_restored", acc_ids.size(), 4);
    drain();
    wb_ids.delete();
    cur_id = 6'd7;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); cycle();
    drain();
    check_eq("post_flush_wb_count", wb_ids.size(), 1);
    if (wb_ids.size() > 0) check_eq("post_flush_wb_id", wb_ids[0], 7);

    // Asynchronous reset with 2 queued and 1 result buffered
    cur_id = 6'd40;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    check_eq("pre_rst_wb_valid", wb_valid, 1'b1);
    check_eq("pre_rst_iss_ready", iss_ready, 1'b0);
    async_reset_pulse();
    check_eq("arst_iss_ready", iss_ready, 1'b1);
    check_eq("arst_inst_valid", inst_valid, 1'b0);
    check_eq("arst_wb_valid", wb_valid, 1'b0);
    check_eq("arst_inst_id", inst_id, 0);
    check_eq("arst_wb_inst_id", wb_inst_id, 0);
    check_eq("arst_pc", pc, 0);
    release_reset();

    // Result strobe with nothing in flight
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cycle();
    repeat (4) begin drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); cycle(); end
    check_eq("proto_err_sticky", proto_err, 1'b1);
    async_reset_pulse();
    check_eq("proto_err_cleared", proto_err, 1'b0);
    release_reset();

    // Randomized traffic against the model
    cur_id = '0;
    repeat (3000) begin
      drive(1'($urandom % 2), ($urandom % 4) != 0, 1'($urandom % 2),
            ($urandom % 25) == 0, (fu_pend.size() > 0) && (($urandom % 3) == 0));
      cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
